// File: rtl/regfile_dump_pkg.sv
// Shared constants and FSM encoding for the register-file dump engine.
package regfile_dump_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Remaining-word counter must hold 1..NUM_REGS, so it needs one extra bit.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DRAIN = ST_DRAIN
    } state_t;

    // Number of words in an inclusive, wrapping index range. NUM_REGS is a
    // power of two, so the ADDR_W-bit subtraction is already modulo NUM_REGS.
    function automatic logic [CNT_W-1:0] span_len(input logic [ADDR_W-1:0] first,
                                                  input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] diff;
        diff = last - first;
        return {1'b0, diff} + CNT_W'(1);
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// Sequential register-file reader: walks a wrapping index range and streams
// each register value out over a valid/ready interface with an inline
// output holding register.
module regfile_dump
    import regfile_dump_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_first,
    input  logic [ADDR_W-1:0] cfg_last,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic              primed_reg, primed_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic              last_reg, last_next;
    logic              valid_reg, valid_next;
    logic              done_reg, done_next;

    logic out_free;
    logic final_word;

    // The holding register can take a new word when empty or being drained.
    assign out_free   = !valid_reg || out_ready;
    assign final_word = (remaining_reg == CNT_W'(1));

    assign rf_addr   = idx_reg;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_index = index_reg;
    assign out_last  = last_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Walk index, word counter and output holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg       <= '0;
            remaining_reg <= '0;
            primed_reg    <= 1'b0;
            data_reg      <= '0;
            index_reg     <= '0;
            last_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            idx_reg       <= idx_next;
            remaining_reg <= remaining_next;
            primed_reg    <= primed_next;
            data_reg      <= data_next;
            index_reg     <= index_next;
            last_reg      <= last_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
        end
    end

    // Next-state and datapath control; everything holds unless changed below.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        remaining_next = remaining_reg;
        primed_next    = primed_reg;
        data_next      = data_reg;
        index_next     = index_reg;
        last_next      = last_reg;
        valid_next     = valid_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    idx_next       = cfg_first;
                    remaining_next = span_len(cfg_first, cfg_last);
                    primed_next    = 1'b0;
                    state_next     = FETCH;
                end
            end

            FETCH: begin
                if (abort) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    state_next = IDLE;
                end else if (!primed_reg) begin
                    // Give the new read address one full cycle before the
                    // first sample of rf_data.
                    primed_next = 1'b1;
                end else if (out_free) begin
                    data_next      = rf_data;
                    index_next     = idx_reg;
                    last_next      = final_word;
                    valid_next     = 1'b1;
                    idx_next       = idx_reg + ADDR_W'(1);
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (final_word) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (abort) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    state_next = IDLE;
                end else if (valid_reg && out_ready) begin
                    valid_next = 1'b0;
                    last_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: the expected word stream is built
// from the configured range as a queue of indices and looked up in a
// bench-side register array.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] cfg_first;
    logic [ADDR_W-1:0] cfg_last;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf_mem [NUM_REGS];

    int checks = 0;
    int errors = 0;

    assign rf_data = rf_mem[rf_addr];

    regfile_dump dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"},  out_data,  0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_last"},  out_last,  0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_addr"},  rf_addr,   0);
    endtask

    // Runs one dump from a point #1 after a clock edge with the DUT idle.
    // mode: 0 ready always high, 1 ready pattern 1,0,0, 2 random ready.
    // abort_after>0 aborts right after that many handshakes.
    task automatic do_dump(input int first, input int last, input int mode,
                           input int abort_after, input bit extra_start,
                           input bit abort_at_start);
        int n, cyc, hs, exp_i;
        int q[$];
        bit stall, finishing;
        logic [DATA_W-1:0] held_data;
        logic [ADDR_W-1:0] held_index;
        logic              held_last;

        n = ((last - first + NUM_REGS) % NUM_REGS) + 1;
        for (int k = 0; k < n; k++) q.push_back((first + k) % NUM_REGS);
        $display("dump first=%0d last=%0d words=%0d mode=%0d abort_after=%0d",
                 first, last, n, mode, abort_after);

        cfg_first = ADDR_W'(first);
        cfg_last  = ADDR_W'(last);
        start     = 1'b1;
        abort     = abort_at_start;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_first = ADDR_W'($urandom);
        cfg_last  = ADDR_W'($urandom);
        chk("busy_on_start", busy, 1);
        chk("rf_addr_start", rf_addr, first);

        cyc = 0; hs = 0; stall = 0; finishing = 0;
        held_data = '0; held_index = '0; held_last = 1'b0;
        forever begin
            if (finishing) begin
                chk("done_pulse", done, 1);
                chk("busy_after_done", busy, 0);
                chk("valid_after_done", out_valid, 0);
                if (mode == 0) chk("done_edge", cyc, n + 2);
                break;
            end
            chk("no_early_done", done, 0);
            if (abort_after > 0 && hs == abort_after) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_valid", out_valid, 0);
                chk("abort_last", out_last, 0);
                chk("abort_busy", busy, 0);
                chk("abort_no_done", done, 0);
                break;
            end
            if (cyc == 1) begin
                chk("rf_addr_hold", rf_addr, first);
                chk("valid_t1", out_valid, 0);
            end
            if (cyc == 2) chk("valid_t2", out_valid, 1);
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_data);
                chk("stall_index", out_index, held_index);
                chk("stall_last", out_last, held_last);
            end

            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc < 2) || (((cyc - 2) % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = extra_start && (cyc == 3);
            if (start) begin
                cfg_first = ADDR_W'($urandom);
                cfg_last  = ADDR_W'($urandom);
            end

            stall = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_word", 1, 0);
                    end else begin
                        exp_i = q.pop_front();
                        $display("  word idx=%0d data=%08h last=%0d", out_index, out_data, out_last);
                        chk("out_index", out_index, exp_i);
                        chk("out_data", out_data, rf_mem[exp_i]);
                        chk("out_last", out_last, q.size() == 0);
                        hs++;
                        finishing = (q.size() == 0);
                    end
                end else begin
                    stall      = 1;
                    held_data  = out_data;
                    held_index = out_index;
                    held_last  = out_last;
                end
            end

            @(posedge clk); #1;
            cyc++;
            if (cyc > 300) begin
                chk("timeout", 0, 1);
                break;
            end
        end

        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_valid", out_valid, 0);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        cfg_first = '0;
        cfg_last  = '0;
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);

        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_outputs_zero("post_reset");

        // abort in IDLE does nothing
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_valid", out_valid, 0);

        // full range, plus a start while busy that must be dropped
        do_dump(0, 31, 0, 0, 1, 0);
        // wrap-around range
        do_dump(30, 1, 0, 0, 0, 0);
        // single word
        do_dump(5, 5, 0, 0, 0, 0);
        // backpressure pattern
        do_dump(0, 7, 1, 0, 0, 0);
        // abort after third handshake, then a fresh dump from its own first
        do_dump(0, 31, 0, 3, 0, 0);
        do_dump(12, 14, 0, 0, 0, 0);
        // abort together with start in IDLE: start wins
        do_dump(20, 22, 0, 0, 0, 1);

        // asynchronous reset in the middle of a dump
        cfg_first = 5'd0;
        cfg_last  = 5'd31;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("after_reset_busy", busy, 0);
            chk("after_reset_done", done, 0);
            chk("after_reset_valid", out_valid, 0);
        end

        // randomized data and ranges
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
        for (int r = 0; r < 8; r++) begin
            do_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 2,
                    (r % 3 == 2) ? 2 : 0, (r % 2) == 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
